div_unit: RTL
=============

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 clk  input  1  — Single clock; all state updates on its rising edge.
REQ-002 rst  input  1  — Synchronous reset, active-high.
REQ-003 flush  input  1  — Pipeline exception/flush; cancels any divide in flight.
REQ-004 stall_all  input  1  — Global memory stall; while high, the EX stage does not advance.
REQ-005 start  input  1  — EX stage holds a DIV/DIVU instruction; stays high until the instruction leaves EX.
REQ-006 signed_div  input  1  — 1 selects DIV (two's complement); 0 selects DIVU.
REQ-007 a  input  32  — Dividend (rs).
REQ-008 b  input  32  — Divisor (rt).
REQ-009 div_stall  output  1  — Request to hazard logic to freeze the front end while a divide is pending.
REQ-010 ready  output  1  — Result valid.
REQ-011 result  output  64  — {hi=remainder, lo=quotient}.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-013 In IDLE with start=1 and flush=0, the block SHALL latch |a| and |b|, the quotient sign (a[31]^b[31])&signed_div, and the remainder sign a[31]&signed_div; it SHALL clear the iteration count and go to BUSY.
REQ-014 Absolute values SHALL be taken only when signed_div=1; otherwise operands are used unmodified as unsigned values.
REQ-015 In BUSY, the block SHALL perform one radix-2 restoring iteration per cycle, shift-subtract over a 33-bit partial remainder, and produce one quotient bit per cycle MSB-first.
REQ-016 After exactly 32 BUSY cycles, the block SHALL enter DONE: a start accepted in cycle T gives DONE and ready=1 in cycle T+33.
REQ-017 On entry to DONE, the quotient and remainder SHALL be negated where the latched signs require it, and result SHALL be registered.
REQ-018 For b=0, result SHALL be {hi=a, lo=32'hFFFFFFFF}, independent of signed_div.
REQ-019 For signed 32'h80000000 / 32'hFFFFFFFF, result SHALL be {hi=0, lo=32'h80000000} (wrap, no trap).
REQ-020 div_stall SHALL be combinational: (IDLE & start & ~flush) | BUSY. It SHALL be 0 in DONE.
REQ-021 In DONE, ready=1 and result SHALL hold stable while stall_all=1.
REQ-022 DONE SHALL return to IDLE in the first cycle with stall_all=0; ready SHALL drop the following cycle.
REQ-023 start SHALL be ignored outside IDLE.
REQ-024 The instruction in EX SHALL NOT re-trigger a divide after DONE, because it leaves EX in the same cycle DONE exits.
REQ-025 flush=1 in any state SHALL force IDLE next cycle, clear ready, and discard partial results; flush has priority over start and stall_all.
REQ-026 stall_all SHALL NOT pause BUSY iterations.
REQ-027 ready and result SHALL change only on clock edges.

Reset
REQ-028 With rst=1 at a clock edge, the block SHALL set state=IDLE, ready=0, result=64'h0, iteration count=0, and clear latched operands and sign flags.
REQ-029 Reset SHALL take priority over flush and start, including reset asserted mid-BUSY.
REQ-030 div_stall SHALL be 0 in the cycle after reset unless start=1.

Configuration
REQ-031 Macro DIV_ZERO_FAST_EN, when defined: an IDLE start with b=0 SHALL go directly to DONE, so ready=1 at T+1 and div_stall is high only in cycle T.
REQ-032 When DIV_ZERO_FAST_EN is undefined: b=0 SHALL take the full 32 BUSY cycles (ready at T+33) and produce the same result value as REQ-018.

Verification
REQ-033 DIVU a=100, b=7, start at T: div_stall=1 for T..T+32, then ready=1 at T+33 with result={hi=2, lo=14}.
REQ-034 DIV a=-7 (32'hFFFFFFF9), b=2: result={hi=32'hFFFFFFFF, lo=32'hFFFFFFFD}; separately, 32'h80000000 / 32'hFFFFFFFF gives {0, 32'h80000000}.
REQ-035 DIV a=5, b=0: result={hi=5, lo=32'hFFFFFFFF}; ready at T+1 with DIV_ZERO_FAST_EN, at T+33 without.
REQ-036 Flush at T+10 during BUSY: IDLE at T+11 with div_stall=0 and ready=0; a new start at T+12 (a=9, b=3) gives ready at T+45 with {0, 3}.
REQ-037 stall_all=1 from T+33 to T+35: ready=1 and result constant through T+35; IDLE at T+36; ready=0 at T+37.
REQ-038 rst asserted at T+20 mid-BUSY: all outputs return to reset values next cycle, and no stale result appears.

Source files
------------

// File: rtl/div_if.sv
// div_if: EX-stage handshake bundle between the pipeline and the divider.
interface div_if;
  logic        flush;
  logic        stall_all;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        div_stall;
  logic        ready;
  logic [63:0] result;
  modport master(output flush, stall_all, start, signed_div, a, b, input div_stall, ready, result);
  modport slave(input flush, stall_all, start, signed_div, a, b, output div_stall, ready, result);
endinterface

// File: rtl/div_unit.sv
// div_unit: 32-cycle radix-2 restoring DIV/DIVU, result {hi=rem, lo=quot}.
// Define DIV_ZERO_FAST_EN to finish divide-by-zero in one cycle.
module div_unit (
  input logic clk,
  input logic rst,
  div_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      r_state, w_next;
  logic [32:0] r_rem;
  logic [31:0] r_q, r_d;
  logic [4:0]  r_cnt;
  logic        r_qs, r_rs, r_dz, r_ready;
  logic [63:0] r_result;
  logic        w_go, w_fast;
  logic [31:0] w_abs_a, w_abs_b, w_qn, w_qf, w_rf;
  logic [32:0] w_sh, w_rn;
  logic [33:0] w_sub;
  logic [63:0] w_res;
  assign w_go    = r_state == IDLE && bus.start && !bus.flush;
  assign w_abs_a = bus.signed_div && bus.a[31] ? -bus.a : bus.a;
  assign w_abs_b = bus.signed_div && bus.b[31] ? -bus.b : bus.b;
`ifdef DIV_ZERO_FAST_EN
  assign w_fast  = w_go && bus.b == 32'd0;
`else
  assign w_fast  = 1'b0;
`endif
  assign w_sh  = {r_rem[31:0], r_q[31]};
  assign w_sub = {1'b0, w_sh} - {2'b0, r_d};
  assign w_rn  = w_sub[33] ? w_sh : w_sub[32:0];
  assign w_qn  = {r_q[30:0], ~w_sub[33]};
  assign w_qf  = r_dz ? 32'hFFFF_FFFF : r_qs ? -w_qn : w_qn;
  // Remainder of x/0 is |x|; restoring its sign reproduces the original dividend.
  assign w_rf  = r_rs ? -w_rn[31:0] : w_rn[31:0];
  assign w_res = r_state == IDLE ? {bus.a, 32'hFFFF_FFFF} : {w_rf, w_qf};
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_go ? (w_fast ? DONE : BUSY) : IDLE;
      BUSY:    w_next = r_cnt == 5'd31 ? DONE : BUSY;
      DONE:    w_next = bus.stall_all ? DONE : IDLE;
      default: w_next = IDLE;
    endcase
    if (bus.flush) w_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rem    <= '0;
      r_q      <= '0;
      r_d      <= '0;
      r_cnt    <= '0;
      r_qs     <= 1'b0;
      r_rs     <= 1'b0;
      r_dz     <= 1'b0;
      r_ready  <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= w_next == DONE;
      if (w_go) begin
        r_rem <= '0;
        r_q   <= w_abs_a;
        r_d   <= w_abs_b;
        r_cnt <= '0;
        r_qs  <= (bus.a[31] ^ bus.b[31]) & bus.signed_div;
        r_rs  <= bus.a[31] & bus.signed_div;
        r_dz  <= bus.b == 32'd0;
      end else if (r_state == BUSY) begin
        r_rem <= w_rn;
        r_q   <= w_qn;
        r_cnt <= r_cnt + 5'd1;
      end
      if (w_next == DONE && r_state != DONE) r_result <= w_res;
    end
  end
  assign bus.div_stall = w_go || r_state == BUSY;
  assign bus.ready     = r_ready;
  assign bus.result    = r_result;
endmodule
